// File: rtl/sys_sequencer_pkg.sv
// Shared types and status-code map for the power-up / shutdown sequencer.
// Status codes are laid out as OK, PS_SHUTDOWN, cfg OOB block, system faults, board classes, timeouts.
package sys_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE         = 4'd1,
    ST_RELEASE_SD_F = 4'd2,
    ST_PULSE_SD_RST = 4'd3,
    ST_SD_RST_DELAY = 4'd4,
    ST_START_DMA    = 4'd5,
    ST_START_SPI    = 4'd6,
    ST_RUNNING      = 4'd7,
    ST_HALTED       = 4'd8
  } state_t;

  localparam int CODE_W = 20;
  typedef logic [CODE_W-1:0] code_t;

  localparam code_t CODE_OK          = 20'd1;
  localparam code_t CODE_PS_SHUTDOWN = 20'd2;
  localparam int    CODE_OOB_BASE    = 3;

  function automatic code_t code_cfg_oob(int idx);
    return code_t'(CODE_OOB_BASE + idx);
  endfunction

  // K: first code after the cfg out-of-bounds block.
  function automatic code_t code_lock_viol(int n_cfg_oob);
    return code_t'(CODE_OOB_BASE + n_cfg_oob);
  endfunction

  function automatic code_t code_shutdown_sense(int n_cfg_oob);
    return code_t'(CODE_OOB_BASE + n_cfg_oob + 1);
  endfunction

  function automatic code_t code_ext_shutdown(int n_cfg_oob);
    return code_t'(CODE_OOB_BASE + n_cfg_oob + 2);
  endfunction

  function automatic code_t code_of(int cls, int n_cfg_oob);
    return code_t'(CODE_OOB_BASE + n_cfg_oob + 3 + cls);
  endfunction

  function automatic code_t code_buf_timeout(int n_cfg_oob, int n_classes);
    return code_of(n_classes, n_cfg_oob);
  endfunction

  function automatic code_t code_spi_timeout(int n_cfg_oob, int n_classes);
    return code_t'(code_of(n_classes, n_cfg_oob) + 20'd1);
  endfunction

endpackage

// File: rtl/sys_sequencer_if.sv
// PS-side register bundle: enables/acks/mask in, status/summary/counter/interrupt out.
interface sys_sequencer_if #(
  parameter int N_FAULT_CLASSES = 11
);
  logic                       sys_en;
  logic                       irq_ack;
  logic [N_FAULT_CLASSES-1:0] fault_mask;
  logic [31:0]                status_word;
  logic [N_FAULT_CLASSES-1:0] fault_summary;
  logic [31:0]                run_cycles;
  logic                       ps_interrupt;

  modport master (
    output sys_en, irq_ack, fault_mask,
    input  status_word, fault_summary, run_cycles, ps_interrupt
  );

  modport slave (
    input  sys_en, irq_ack, fault_mask,
    output status_word, fault_summary, run_cycles, ps_interrupt
  );
endinterface

// File: rtl/sys_sequencer_prio_enc.sv
// First-set (lowest index) priority encoder with a valid flag.
module prio_enc #(
  parameter int N = 8,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         valid
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sys_sequencer.sv
// Power-up / shutdown sequencer: boots the shim in timed steps, watches halt sources while
// running, and latches a status word, sticky fault summary, run-cycle counter and interrupt.
module sys_sequencer
  import sys_sequencer_pkg::*;
#(
  parameter int N_BOARDS             = 8,
  parameter int BOARD_W              = (N_BOARDS > 1) ? $clog2(N_BOARDS) : 1,
  parameter int N_CFG_OOB            = 5,
  parameter int N_FAULT_CLASSES      = 11,
  parameter int SHUTDOWN_FORCE_DELAY = 2500000,
  parameter int SHUTDOWN_RESET_PULSE = 25000,
  parameter int SHUTDOWN_RESET_DELAY = 25000000,
  parameter int BUF_LOAD_WAIT        = 250000000,
  parameter int SPI_START_WAIT       = 250000000
) (
  input  logic                                clk,
  input  logic                                rst,
  sys_sequencer_if.slave                      ps,
  input  logic                                dac_buf_full,
  input  logic                                spi_running,
  input  logic                                ext_shutdown,
  input  logic [N_CFG_OOB-1:0]                cfg_oob,
  input  logic                                lock_viol,
  input  logic                                shutdown_sense,
  input  logic [BOARD_W-1:0]                  sense_num,
  input  logic [N_FAULT_CLASSES*N_BOARDS-1:0] brd_fault,
  output logic                                sys_rst,
  output logic                                unlock_cfg,
  output logic                                dma_en,
  output logic                                spi_en,
  output logic                                trig_en,
  output logic                                shutdown_force,
  output logic                                n_shutdown_rst
);

  localparam int OOB_W = (N_CFG_OOB > 1) ? $clog2(N_CFG_OOB) : 1;
  localparam int CLS_W = (N_FAULT_CLASSES > 1) ? $clog2(N_FAULT_CLASSES) : 1;

  typedef struct packed {
    state_t                     state;
    logic [31:0]                timer;
    logic                       sys_rst;
    logic                       unlock_cfg;
    logic                       dma_en;
    logic                       spi_en;
    logic                       trig_en;
    logic                       shutdown_force;
    logic                       n_shutdown_rst;
    logic [7:0]                 board_num;
    code_t                      code;
    logic [N_FAULT_CLASSES-1:0] fault_summary;
    logic [31:0]                run_cycles;
    logic                       irq;
  } regs_t;

  localparam regs_t REGS_RESET = '{
    state:          ST_IDLE,
    timer:          32'd0,
    sys_rst:        1'b1,
    unlock_cfg:     1'b1,
    dma_en:         1'b0,
    spi_en:         1'b0,
    trig_en:        1'b0,
    shutdown_force: 1'b1,
    n_shutdown_rst: 1'b1,
    board_num:      8'd0,
    code:           CODE_OK,
    fault_summary:  '0,
    run_cycles:     32'd0,
    irq:            1'b0
  };

  regs_t r, nx;

  // Fault decode: per-class unmasked activity, lowest active class, lowest board in it.
  logic [N_FAULT_CLASSES-1:0] class_active;
  logic [CLS_W-1:0]           cls_idx;
  logic                       cls_valid;
  logic [N_BOARDS-1:0]        sel_row;
  logic [BOARD_W-1:0]         brd_idx;
  logic                       brd_valid;
  logic [OOB_W-1:0]           oob_idx;
  logic                       oob_valid;

  always_comb begin
    class_active = '0;
    for (int c = 0; c < N_FAULT_CLASSES; c++) begin
      class_active[c] = (|brd_fault[c*N_BOARDS +: N_BOARDS]) & ~ps.fault_mask[c];
    end
  end

  always_comb begin
    sel_row = '0;
    for (int c = 0; c < N_FAULT_CLASSES; c++) begin
      if (cls_idx == CLS_W'(c)) sel_row = brd_fault[c*N_BOARDS +: N_BOARDS];
    end
  end

  prio_enc #(.N(N_CFG_OOB), .W(OOB_W)) u_oob_enc (
    .req   (cfg_oob),
    .idx   (oob_idx),
    .valid (oob_valid)
  );

  prio_enc #(.N(N_FAULT_CLASSES), .W(CLS_W)) u_class_enc (
    .req   (class_active),
    .idx   (cls_idx),
    .valid (cls_valid)
  );

  prio_enc #(.N(N_BOARDS), .W(BOARD_W)) u_board_enc (
    .req   (sel_row),
    .idx   (brd_idx),
    .valid (brd_valid)
  );

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r <= REGS_RESET;
    else     r <= nx;
  end

  logic       do_halt;
  code_t      halt_code;
  logic [7:0] halt_board;
  logic       irq_event;

  always_comb begin
    nx         = r;
    do_halt    = 1'b0;
    halt_code  = CODE_OK;
    halt_board = 8'd0;
    irq_event  = 1'b0;

    unique case (r.state)
      ST_IDLE: begin
        if (ps.sys_en) begin
          if (oob_valid) begin
            do_halt   = 1'b1;
            halt_code = code_cfg_oob(int'(oob_idx));
          end else begin
            nx.state          = ST_RELEASE_SD_F;
            nx.timer          = 32'd0;
            nx.sys_rst        = 1'b0;
            nx.unlock_cfg     = 1'b0;
            nx.shutdown_force = 1'b0;
          end
        end
      end

      ST_RELEASE_SD_F: begin
        if (!ps.sys_en) begin
          do_halt   = 1'b1;
          halt_code = CODE_PS_SHUTDOWN;
        end else if (r.timer == 32'(SHUTDOWN_FORCE_DELAY)) begin
          nx.state          = ST_PULSE_SD_RST;
          nx.timer          = 32'd0;
          nx.n_shutdown_rst = 1'b0;
        end else begin
          nx.timer = r.timer + 32'd1;
        end
      end

      ST_PULSE_SD_RST: begin
        if (!ps.sys_en) begin
          do_halt   = 1'b1;
          halt_code = CODE_PS_SHUTDOWN;
        end else if (r.timer == 32'(SHUTDOWN_RESET_PULSE)) begin
          nx.state          = ST_SD_RST_DELAY;
          nx.timer          = 32'd0;
          nx.n_shutdown_rst = 1'b1;
        end else begin
          nx.timer = r.timer + 32'd1;
        end
      end

      ST_SD_RST_DELAY: begin
        if (!ps.sys_en) begin
          do_halt   = 1'b1;
          halt_code = CODE_PS_SHUTDOWN;
        end else if (r.timer == 32'(SHUTDOWN_RESET_DELAY)) begin
          nx.state  = ST_START_DMA;
          nx.timer  = 32'd0;
          nx.dma_en = 1'b1;
        end else begin
          nx.timer = r.timer + 32'd1;
        end
      end

      ST_START_DMA: begin
        // A full buffer on the timeout cycle still counts as a successful preload.
        if (!ps.sys_en) begin
          do_halt   = 1'b1;
          halt_code = CODE_PS_SHUTDOWN;
        end else if (dac_buf_full) begin
          nx.state  = ST_START_SPI;
          nx.timer  = 32'd0;
          nx.spi_en = 1'b1;
        end else if (r.timer == 32'(BUF_LOAD_WAIT)) begin
          do_halt   = 1'b1;
          halt_code = code_buf_timeout(N_CFG_OOB, N_FAULT_CLASSES);
        end else begin
          nx.timer = r.timer + 32'd1;
        end
      end

      ST_START_SPI: begin
        if (!ps.sys_en) begin
          do_halt   = 1'b1;
          halt_code = CODE_PS_SHUTDOWN;
        end else if (spi_running) begin
          nx.state      = ST_RUNNING;
          nx.timer      = 32'd0;
          nx.trig_en    = 1'b1;
          nx.run_cycles = 32'd0;
          irq_event     = 1'b1;
        end else if (r.timer == 32'(SPI_START_WAIT)) begin
          do_halt   = 1'b1;
          halt_code = code_spi_timeout(N_CFG_OOB, N_FAULT_CLASSES);
        end else begin
          nx.timer = r.timer + 32'd1;
        end
      end

      ST_RUNNING: begin
        if (r.run_cycles != 32'hFFFF_FFFF) nx.run_cycles = r.run_cycles + 32'd1;
        if (!ps.sys_en) begin
          do_halt   = 1'b1;
          halt_code = CODE_PS_SHUTDOWN;
        end else if (lock_viol) begin
          do_halt   = 1'b1;
          halt_code = code_lock_viol(N_CFG_OOB);
        end else if (shutdown_sense) begin
          do_halt    = 1'b1;
          halt_code  = code_shutdown_sense(N_CFG_OOB);
          halt_board = 8'(sense_num);
        end else if (ext_shutdown) begin
          do_halt   = 1'b1;
          halt_code = code_ext_shutdown(N_CFG_OOB);
        end else if (cls_valid && brd_valid) begin
          do_halt    = 1'b1;
          halt_code  = code_of(int'(cls_idx), N_CFG_OOB);
          halt_board = 8'(brd_idx);
        end
      end

      ST_HALTED: begin
        if (!ps.sys_en) begin
          nx.state         = ST_IDLE;
          nx.code          = CODE_OK;
          nx.board_num     = 8'd0;
          nx.fault_summary = '0;
          nx.unlock_cfg    = 1'b1;
        end
      end

      default: nx = REGS_RESET;
    endcase

    if (do_halt) begin
      nx.state          = ST_HALTED;
      nx.timer          = 32'd0;
      nx.code           = halt_code;
      nx.board_num      = halt_board;
      nx.sys_rst        = 1'b1;
      nx.shutdown_force = 1'b1;
      nx.n_shutdown_rst = 1'b1;
      nx.dma_en         = 1'b0;
      nx.spi_en         = 1'b0;
      nx.trig_en        = 1'b0;
      nx.fault_summary  = class_active;
      irq_event         = 1'b1;
    end

    // A new event outranks an acknowledge arriving in the same cycle.
    if (irq_event)       nx.irq = 1'b1;
    else if (ps.irq_ack) nx.irq = 1'b0;
  end

  assign sys_rst          = r.sys_rst;
  assign unlock_cfg       = r.unlock_cfg;
  assign dma_en           = r.dma_en;
  assign spi_en           = r.spi_en;
  assign trig_en          = r.trig_en;
  assign shutdown_force   = r.shutdown_force;
  assign n_shutdown_rst   = r.n_shutdown_rst;
  assign ps.status_word   = {r.board_num, r.code, r.state};
  assign ps.fault_summary = r.fault_summary;
  assign ps.run_cycles    = r.run_cycles;
  assign ps.ps_interrupt  = r.irq;

endmodule

// File: tb/tb_sys_sequencer.sv
// Scoreboard bench for sys_sequencer: a phase-level reference model predicts every cycle's
// outputs into a queue; a negedge monitor pops and compares, plus fixed-value anchor checks.
module tb_sys_sequencer;

  localparam int NB    = 8;
  localparam int BW    = 3;
  localparam int NO    = 5;
  localparam int NC    = 11;
  localparam int D_SF  = 4;
  localparam int D_PR  = 2;
  localparam int D_SR  = 6;
  localparam int W_BUF = 20;
  localparam int W_SPI = 20;
  localparam int K     = 3 + NO;

  localparam int P_IDLE = 0, P_REL = 1, P_PULSE = 2, P_SRD = 3,
                 P_DMA = 4, P_SPI = 5, P_RUN = 6, P_HALT = 7;

  logic clk = 1'b0;
  logic rst;
  logic dac_buf_full, spi_running, ext_shutdown, lock_viol, shutdown_sense;
  logic [NO-1:0]    cfg_oob;
  logic [BW-1:0]    sense_num;
  logic [NC*NB-1:0] brd_fault;
  logic sys_rst, unlock_cfg, dma_en, spi_en, trig_en, shutdown_force, n_shutdown_rst;

  sys_sequencer_if #(.N_FAULT_CLASSES(NC)) ps ();

  sys_sequencer #(
    .N_BOARDS(NB), .BOARD_W(BW), .N_CFG_OOB(NO), .N_FAULT_CLASSES(NC),
    .SHUTDOWN_FORCE_DELAY(D_SF), .SHUTDOWN_RESET_PULSE(D_PR), .SHUTDOWN_RESET_DELAY(D_SR),
    .BUF_LOAD_WAIT(W_BUF), .SPI_START_WAIT(W_SPI)
  ) dut (
    .clk(clk), .rst(rst), .ps(ps),
    .dac_buf_full(dac_buf_full), .spi_running(spi_running), .ext_shutdown(ext_shutdown),
    .cfg_oob(cfg_oob), .lock_viol(lock_viol), .shutdown_sense(shutdown_sense),
    .sense_num(sense_num), .brd_fault(brd_fault),
    .sys_rst(sys_rst), .unlock_cfg(unlock_cfg), .dma_en(dma_en), .spi_en(spi_en),
    .trig_en(trig_en), .shutdown_force(shutdown_force), .n_shutdown_rst(n_shutdown_rst)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        sys_rst, unlock_cfg, dma_en, spi_en, trig_en, shutdown_force, n_shutdown_rst;
    logic [31:0] status_word;
    logic [NC-1:0] fault_summary;
    logic [31:0] run_cycles;
    logic        ps_interrupt;
  } obs_t;

  typedef struct packed {
    logic [31:0]   sw;
    logic [NC-1:0] fs;
    logic          irq;
  } anc_t;

  obs_t  exp_q[$];
  int    exp_cyc_q[$];
  anc_t  anc_q[$];
  int    anc_cyc_q[$];
  string anc_name_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(string name, logic [127:0] act, logic [127:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_phase, m_cnt, m_code;
  logic [7:0]  m_board;
  logic [NC-1:0] m_fs;
  logic [31:0] m_run;
  logic        m_irq, m_unlock_halt;

  function automatic int phase_delay(int p);
    case (p)
      P_REL:   return D_SF;
      P_PULSE: return D_PR;
      default: return D_SR;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_cnt = 0; m_code = 1; m_board = 8'd0;
    m_fs = '0; m_run = 32'd0; m_irq = 1'b0; m_unlock_halt = 1'b0;
  endtask

  task automatic model_step();
    int first_c, first_b, hc, prev;
    logic [NC-1:0] act;
    logic h, ev;
    logic [7:0] hb;
    if (rst) begin
      model_reset();
      return;
    end
    first_c = -1; first_b = 0; act = '0;
    for (int c = 0; c < NC; c++)
      for (int b = 0; b < NB; b++)
        if (brd_fault[c*NB+b] && !ps.fault_mask[c]) begin
          act[c] = 1'b1;
          if (first_c < 0) begin first_c = c; first_b = b; end
        end
    h = 1'b0; ev = 1'b0; hc = 0; hb = 8'd0; prev = m_phase;
    case (m_phase)
      P_IDLE:
        if (ps.sys_en) begin
          if (cfg_oob != '0) begin
            for (int i = NO - 1; i >= 0; i--) if (cfg_oob[i]) hc = 3 + i;
            h = 1'b1;
          end else begin
            m_phase = P_REL; m_cnt = 0;
          end
        end
      P_REL, P_PULSE, P_SRD:
        if (!ps.sys_en) begin h = 1'b1; hc = 2; end
        else if (m_cnt == phase_delay(m_phase)) begin m_phase++; m_cnt = 0; end
        else m_cnt++;
      P_DMA:
        if (!ps.sys_en) begin h = 1'b1; hc = 2; end
        else if (dac_buf_full) begin m_phase = P_SPI; m_cnt = 0; end
        else if (m_cnt == W_BUF) begin h = 1'b1; hc = K + 3 + NC; end
        else m_cnt++;
      P_SPI:
        if (!ps.sys_en) begin h = 1'b1; hc = 2; end
        else if (spi_running) begin m_phase = P_RUN; m_run = 32'd0; ev = 1'b1; end
        else if (m_cnt == W_SPI) begin h = 1'b1; hc = K + 4 + NC; end
        else m_cnt++;
      P_RUN: begin
        if (m_run != 32'hFFFF_FFFF) m_run++;
        if (!ps.sys_en)          begin h = 1'b1; hc = 2; end
        else if (lock_viol)      begin h = 1'b1; hc = K; end
        else if (shutdown_sense) begin h = 1'b1; hc = K + 1; hb = 8'(sense_num); end
        else if (ext_shutdown)   begin h = 1'b1; hc = K + 2; end
        else if (first_c >= 0)   begin h = 1'b1; hc = K + 3 + first_c; hb = 8'(first_b); end
      end
      default:
        if (!ps.sys_en) begin m_phase = P_IDLE; m_code = 1; m_board = 8'd0; m_fs = '0; end
    endcase
    if (h) begin
      m_unlock_halt = (prev == P_IDLE);
      m_phase = P_HALT; m_code = hc; m_board = hb; m_fs = act; ev = 1'b1;
    end
    if (ev) m_irq = 1'b1;
    else if (ps.irq_ack) m_irq = 1'b0;
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    logic idle_or_halt;
    idle_or_halt     = (m_phase == P_IDLE) || (m_phase == P_HALT);
    o.sys_rst        = idle_or_halt;
    o.shutdown_force = idle_or_halt;
    o.unlock_cfg     = (m_phase == P_IDLE) || ((m_phase == P_HALT) && m_unlock_halt);
    o.dma_en         = (m_phase >= P_DMA) && (m_phase <= P_RUN);
    o.spi_en         = (m_phase == P_SPI) || (m_phase == P_RUN);
    o.trig_en        = (m_phase == P_RUN);
    o.n_shutdown_rst = (m_phase != P_PULSE);
    o.status_word    = {m_board, 20'(m_code), 4'(m_phase + 1)};
    o.fault_summary  = m_fs;
    o.run_cycles     = m_run;
    o.ps_interrupt   = m_irq;
    return o;
  endfunction

  // ---------------- monitor ----------------
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    obs_t a, e;
    anc_t ac, ae;
    a = '{sys_rst, unlock_cfg, dma_en, spi_en, trig_en, shutdown_force, n_shutdown_rst,
          ps.status_word, ps.fault_summary, ps.run_cycles, ps.ps_interrupt};
    while (exp_q.size() > 0 && exp_cyc_q[0] == cyc) begin
      e = exp_q.pop_front();
      void'(exp_cyc_q.pop_front());
      check("outputs", 128'(a), 128'(e));
    end
    while (anc_q.size() > 0 && anc_cyc_q[0] == cyc) begin
      ae = anc_q.pop_front();
      void'(anc_cyc_q.pop_front());
      ac = '{ps.status_word, ps.fault_summary, ps.ps_interrupt};
      check(anc_name_q.pop_front(), 128'(ac), 128'(ae));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    model_step();
    exp_q.push_back(model_obs());
    exp_cyc_q.push_back(cyc + 1);
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(int n);
    repeat (n) tick();
  endtask

  // Fixed expectation on the outputs left by the most recent edge.
  task automatic anchor(string name, logic [7:0] brd, int code, int st, logic [NC-1:0] fs, logic irq);
    anc_q.push_back('{{brd, 20'(code), 4'(st)}, fs, irq});
    anc_cyc_q.push_back(cyc);
    anc_name_q.push_back(name);
  endtask

  task automatic clear_inputs();
    dac_buf_full = 0; spi_running = 0; ext_shutdown = 0; lock_viol = 0;
    shutdown_sense = 0; cfg_oob = '0; sense_num = '0; brd_fault = '0;
    ps.irq_ack = 0; ps.fault_mask = '0;
  endtask

  task automatic boot_to_running();
    int guard;
    ps.sys_en = 1;
    guard = 0;
    while (m_phase != P_DMA && guard < 100) begin tick(); guard++; end
    check("boot_bound", 128'(m_phase), 128'(P_DMA));
    dac_buf_full = 1; tick(); dac_buf_full = 0;
    spi_running = 1;  tick(); spi_running = 0;
  endtask

  task automatic go_idle();
    clear_inputs();
    ps.sys_en = 0;
    ticks(2);
  endtask

  initial begin
    rst = 1; ps.sys_en = 0;
    clear_inputs();
    model_reset();
    ticks(3);
    anchor("reset_state", 8'd0, 1, 1, '0, 1'b0);
    rst = 0;
    ticks(2);

    // Nominal boot with interrupt held until acknowledged.
    boot_to_running();
    anchor("run_entry", 8'd0, 1, 7, '0, 1'b1);
    ticks(5);
    anchor("irq_held", 8'd0, 1, 7, '0, 1'b1);
    ps.irq_ack = 1; tick(); ps.irq_ack = 0;
    anchor("irq_cleared", 8'd0, 1, 7, '0, 1'b0);
    ps.sys_en = 0; tick();
    anchor("ps_shutdown", 8'd0, 2, 8, '0, 1'b1);
    go_idle();

    // cfg out-of-bounds straight from IDLE: lowest set bit is index 2.
    ps.irq_ack = 1; tick(); ps.irq_ack = 0;
    cfg_oob = 5'b10100; ps.sys_en = 1; tick();
    anchor("cfg_oob_halt", 8'd0, 5, 8, '0, 1'b1);
    go_idle();
    anchor("back_to_idle", 8'd0, 1, 1, '0, 1'b1);

    // Board faults, unmasked then with class 2 masked, then all masked.
    boot_to_running();
    brd_fault[2*NB+5] = 1; brd_fault[2*NB+3] = 1; brd_fault[4*NB+0] = 1;
    tick();
    anchor("fault_cls2", 8'd3, K + 5, 8, 11'b000_0001_0100, 1'b1);
    go_idle();
    boot_to_running();
    ps.fault_mask = 11'b000_0000_0100;
    brd_fault[2*NB+5] = 1; brd_fault[2*NB+3] = 1; brd_fault[4*NB+0] = 1;
    tick();
    anchor("fault_masked2", 8'd0, K + 7, 8, 11'b000_0001_0000, 1'b1);
    go_idle();
    boot_to_running();
    ps.fault_mask = '1;
    brd_fault[2*NB+5] = 1; brd_fault[2*NB+3] = 1; brd_fault[4*NB+0] = 1;
    ticks(8);
    anchor("all_masked_run", 8'd0, 1, 7, '0, 1'b1);
    ps.sys_en = 0; tick();
    anchor("all_masked_fs", 8'd0, 2, 8, '0, 1'b1);
    go_idle();

    // DAC buffer never fills.
    ps.sys_en = 1;
    ticks(40);
    anchor("buf_timeout", 8'd0, K + 3 + NC, 8, '0, 1'b1);
    go_idle();
    anchor("timeout_idle", 8'd0, 1, 1, '0, 1'b1);

    // Reset in the middle of the shutdown-reset pulse.
    ps.sys_en = 1;
    ticks(7);
    rst = 1; tick(); rst = 0;
    anchor("rst_mid_pulse", 8'd0, 1, 1, '0, 1'b0);
    go_idle();

    // Acknowledge coincident with a new halt event keeps the interrupt set.
    boot_to_running();
    ps.irq_ack = 1; tick();
    ext_shutdown = 1; tick();
    anchor("ack_vs_event", 8'd0, K + 2, 8, '0, 1'b1);
    go_idle();

    // Sense-driven halt reports the sensing board.
    boot_to_running();
    shutdown_sense = 1; sense_num = 3'd6; lock_viol = 0; tick();
    anchor("sense_halt", 8'd6, K + 1, 8, '0, 1'b1);
    go_idle();

    // Randomised traffic.
    for (int i = 0; i < 800; i++) begin
      rst            = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 99) < 4) ps.sys_en = ~ps.sys_en;
      dac_buf_full   = ($urandom_range(0, 99) < 15);
      spi_running    = ($urandom_range(0, 99) < 15);
      ext_shutdown   = ($urandom_range(0, 99) < 1);
      lock_viol      = ($urandom_range(0, 99) < 1);
      shutdown_sense = ($urandom_range(0, 99) < 1);
      sense_num      = BW'($urandom_range(0, NB - 1));
      cfg_oob        = ($urandom_range(0, 99) < 5) ? NO'($urandom) : '0;
      ps.irq_ack     = ($urandom_range(0, 99) < 20);
      if (i % 50 == 0) ps.fault_mask = NC'($urandom);
      brd_fault = '0;
      if ($urandom_range(0, 99) < 3) begin
        brd_fault[$urandom_range(0, NC*NB - 1)] = 1'b1;
        brd_fault[$urandom_range(0, NC*NB - 1)] = 1'b1;
      end
      tick();
    end

    rst = 0; clear_inputs();
    @(negedge clk);
    @(negedge clk);
    check("queue_drain", 128'(exp_q.size() + anc_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sys_sequencer.md
Name: sys_sequencer

Overview:
Parametrised power-up and shutdown sequencer for the shim controller. It generalises the per-board fault manager to N_BOARDS boards and N_FAULT_CLASSES per-board fault classes, and adds a per-class fault mask. It captures a sticky multi-fault summary, holds an acknowledged interrupt, and counts run-time cycles. It sits between the PS config/status registers and the DMA, SPI and trigger subsystems.

Parameters:
N_BOARDS, 8, number of boards; range 1..256.
BOARD_W, $clog2(N_BOARDS) (minimum 1), board index width.
N_CFG_OOB, 5, number of config out-of-bounds inputs.
N_FAULT_CLASSES, 11, number of per-board fault classes.
SHUTDOWN_FORCE_DELAY, 2500000, cycles between releasing shutdown_force and asserting n_shutdown_rst low.
SHUTDOWN_RESET_PULSE, 25000, width of the n_shutdown_rst low pulse.
SHUTDOWN_RESET_DELAY, 25000000, cycles after the pulse before enabling DMA.
BUF_LOAD_WAIT, 250000000, DAC buffer fill timeout.
SPI_START_WAIT, 250000000, SPI start timeout.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
sys_en  in  1  PS system enable
dac_buf_full  in  1  DAC buffer preloaded
spi_running  in  1  SPI subsystem running
ext_shutdown  in  1  external shutdown request
cfg_oob  in  N_CFG_OOB  config out-of-bounds flags; bit i maps to code 3+i
lock_viol  in  1  config lock violation
shutdown_sense  in  1  hardware shutdown sensed
sense_num  in  BOARD_W  board that raised shutdown_sense
brd_fault  in  N_FAULT_CLASSES*N_BOARDS  fault flags; class c, board b at bit c*N_BOARDS+b
fault_mask  in  N_FAULT_CLASSES  1 = ignore that class
irq_ack  in  1  PS interrupt acknowledge
sys_rst, unlock_cfg, dma_en, spi_en, trig_en, shutdown_force, n_shutdown_rst  out  1 each  same meaning as the existing manager
status_word  out  32  {8'(board_num), 20'(status_code), 4'(state)}
fault_summary  out  N_FAULT_CLASSES  sticky: classes active in the halting cycle
run_cycles  out  32  cycles spent in RUNNING, saturating
ps_interrupt  out  1  level interrupt, held until acknowledged

Behaviour:
- Reset values:
  - state=IDLE(1); sys_rst=1, shutdown_force=1, n_shutdown_rst=1, unlock_cfg=1.
  - dma_en=0, spi_en=0, trig_en=0.
  - status_code=OK(1), board_num=0, fault_summary=0, run_cycles=0, ps_interrupt=0, timer=0.
  - rst in any state returns everything to these values on the next edge.
- States: IDLE=1, RELEASE_SD_F=2, PULSE_SD_RST=3, SD_RST_DELAY=4, START_DMA=5, START_SPI=6, RUNNING=7, HALTED=8.
- Status codes:
  - OK=1, PS_SHUTDOWN=2, CFG_OOB_i=3+i.
  - Then, with K=3+N_CFG_OOB: LOCK_VIOL=K, SHUTDOWN_SENSE=K+1, EXT_SHUTDOWN=K+2.
  - Board fault class c = K+3+c.
  - DAC_BUF_FILL_TIMEOUT = K+3+N_FAULT_CLASSES; SPI_START_TIMEOUT = that +1.
- IDLE with sys_en=1:
  - Any cfg_oob bit set -> HALTED; code is the lowest set index; interrupt raised.
  - Otherwise -> RELEASE_SD_F with timer=0; sys_rst, unlock_cfg and shutdown_force deasserted.
- Delay states use a timer that is 0 on entry; exit on the cycle timer==DELAY, so each delay state lasts DELAY+1 cycles.
  - RELEASE_SD_F -> PULSE_SD_RST: n_shutdown_rst goes to 0.
  - PULSE_SD_RST -> SD_RST_DELAY: n_shutdown_rst goes to 1.
  - SD_RST_DELAY -> START_DMA: dma_en goes to 1.
- START_DMA:
  - dac_buf_full -> START_SPI, spi_en=1. dac_buf_full wins over the timeout in the same cycle.
  - timer==BUF_LOAD_WAIT -> HALTED with the fill-timeout code, full safe-state outputs, interrupt.
- START_SPI:
  - spi_running -> RUNNING, trig_en=1, interrupt, run_cycles cleared to 0.
  - Timeout -> HALTED with the SPI-start-timeout code.
- RUNNING: run_cycles increments each cycle and saturates at 0xFFFFFFFF. Halt sources, in priority order:
  1. !sys_en
  2. lock_viol
  3. shutdown_sense (board_num=sense_num)
  4. ext_shutdown
  5. unmasked board fault: lowest class, then lowest board in that class.
- Masked classes never halt and never appear in fault_summary.
- Halt action:
  - sys_rst=1, shutdown_force=1; dma_en, spi_en and trig_en go to 0.
  - fault_summary = OR-reduced per-class unmasked faults in that cycle.
  - Interrupt raised.
- HALTED:
  - Outputs and run_cycles are frozen.
  - On !sys_en -> IDLE: code=OK, board_num=0, fault_summary=0, unlock_cfg=1.
- ps_interrupt:
  - Set on an event; cleared on the cycle after irq_ack=1.
  - If an event and irq_ack occur in the same cycle, the set wins.
  - ps_interrupt does not self-clear.
- sys_en falling in any boot state (2..6): immediate halt with PS_SHUTDOWN and the safe-state outputs.

Decomposition:
- Package sys_sequencer_pkg: state localparams; status-code base constants and a function code_of(class, N_CFG_OOB).
- Sub-module prio_enc #(N): first-set index plus valid flag. Used for cfg_oob, the class select and the board select.

Test Plan:
All scenarios use the parameter set DELAYS=4/2/6, waits=20.
- Nominal boot: sys_en=1 at cycle 0 -> n_shutdown_rst low for 3 cycles after 5 cycles; dma_en at +7 cycles; dac_buf_full then spi_running -> state=7, trig_en=1, ps_interrupt=1 held until irq_ack.
- cfg_oob=5'b10100 with sys_en -> HALTED, code 5, no output toggles except ps_interrupt.
- RUNNING, brd_fault class 2 boards 5 and 3 plus class 4 board 0 -> code K+5, board_num=3, fault_summary=0b10100.
- Same stimulus with fault_mask[2]=1 -> code K+7, board_num=0, fault_summary=0b10000; mask all classes -> stays RUNNING.
- No dac_buf_full -> HALTED on timer==20, code DAC_BUF_FILL_TIMEOUT, dma_en=0; sys_en=0 -> IDLE, code 1.
- rst asserted mid-PULSE_SD_RST -> next edge n_shutdown_rst=1, state=1, run_cycles=0; irq_ack coincident with new fault keeps ps_interrupt=1.
